// File: rtl/lcd1602_pkg.sv
// rtl/lcd1602_pkg.sv - shared states, init commands and opcodes for the LCD1602 write scheduler
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_LOAD,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_e;

    localparam logic [7:0] INIT_CMD0 = 8'h31;
    localparam logic [7:0] INIT_CMD1 = 8'h0C;
    localparam logic [7:0] INIT_CMD2 = 8'h06;
    localparam logic [7:0] INIT_CMD3 = 8'h01;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_CMD0;
            2'd1:    return INIT_CMD1;
            2'd2:    return INIT_CMD2;
            default: return INIT_CMD3;
        endcase
    endfunction

    // Clear and home commands need the long post-transfer wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd1602_rr_arb.sv
// rtl/lcd1602_rr_arb.sv - two-way round-robin grant for the LCD write requesters
module lcd1602_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // last_q = 1 means req1 was granted most recently, so req0 wins a tie.
    logic last_q, last_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                grant_o = last_q ? 2'b01 : 2'b10;
            end else begin
                grant_o = valid_i;
            end
        end
        last_d = last_q;
        if (grant_o[0]) begin
            last_d = 1'b0;
        end else if (grant_o[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lcd1602_sched.sv
// rtl/lcd1602_sched.sv - LCD1602 power-up init plus arbitrated byte writes with enable timing
module lcd1602_sched
    import lcd1602_pkg::*;
#(
    parameter int EN_CYC     = 16,
    parameter int SHORT_WAIT = 64,
    parameter int LONG_WAIT  = 2048,
    parameter int POWER_WAIT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       init_done,
    output logic       busy
);

    localparam logic [15:0] EN_LAST    = 16'(EN_CYC - 1);
    localparam logic [15:0] SHORT_LAST = 16'(SHORT_WAIT - 1);
    localparam logic [15:0] LONG_LAST  = 16'(LONG_WAIT - 1);
    localparam logic [15:0] PWR_LAST   = 16'(POWER_WAIT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        rs_q, rs_d;
    logic [7:0]  dat_q, dat_d;
    logic        init_done_q, init_done_d;
    logic [1:0]  grant;
    logic        arb_en;
    logic [15:0] wait_last;

    assign arb_en    = (state_q == ST_IDLE) && init_done_q;
    assign wait_last = is_long_cmd(rs_q, dat_q) ? LONG_LAST : SHORT_LAST;

    lcd1602_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arb_en),
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rs_d        = rs_q;
        dat_d       = dat_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_INIT_LOAD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_INIT_LOAD: begin
                rs_d    = 1'b0;
                dat_d   = init_cmd(idx_q);
                state_d = ST_SETUP;
            end
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    rs_d    = grant[1] ? req1_rs : req0_rs;
                    dat_d   = grant[1] ? req1_data : req0_data;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    // During init, step through the four commands before opening the bus.
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            dat_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            dat_q       <= dat_d;
            init_done_q <= init_done_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = (state_q == ST_PULSE);
    assign lcd_dat    = dat_q;
    assign init_done  = init_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd1602_sched.sv
// tb/tb_lcd1602_sched.sv - randomized self-checking bench for lcd1602_sched
module tb_lcd1602_sched;

    localparam int EN_CYC     = 2;
    localparam int SHORT_WAIT = 5;
    localparam int LONG_WAIT  = 20;
    localparam int POWER_WAIT = 10;
    localparam int NEVER      = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_rs = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;
    logic       init_done, busy;

    lcd1602_sched #(
        .EN_CYC     (EN_CYC),
        .SHORT_WAIT (SHORT_WAIT),
        .LONG_WAIT  (LONG_WAIT),
        .POWER_WAIT (POWER_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_dat    (lcd_dat),
        .init_done  (init_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: byte queue of expected LCD writes plus cycle-based idle/init timing.
    int         cyc, idle_at, init_at, pulses, en_len, hold_cnt;
    int         acc_total = 0, last_acc_cyc = 0, gap_last = 0;
    bit         last_m, prev_en;
    logic [8:0] prev_bus, cap;
    logic [8:0] exp_q[$];
    int         grants[$];
    bit         pend[2], prs[2], acc[2];
    logic [7:0] pdat[2];
    int         spawn_pct = 0, wd_pct = 0;

    function automatic int wait_len(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? LONG_WAIT : SHORT_WAIT;
    endfunction

    task automatic model_reset();
        cyc = 0; idle_at = NEVER; init_at = NEVER; pulses = 0; en_len = 0; hold_cnt = 0;
        last_m = 1'b1; prev_en = 1'b0; prev_bus = '0; cap = '0;
        exp_q.delete();
        exp_q.push_back(9'h031); exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006); exp_q.push_back(9'h001);
        for (int r = 0; r < 2; r++) begin pend[r] = 1'b0; acc[r] = 1'b0; end
    endtask

    task automatic sample();
        logic [1:0] v, g;
        logic init_exp, idle_m, has_exp;
        int r;
        cyc++;
        if (lcd_en && !prev_en) begin
            has_exp = (exp_q.size() != 0);
            check("en_expected", 32'(has_exp), 32'd1);
            if (has_exp) begin
                cap = exp_q.pop_front();
                check("byte", 32'({lcd_rs, lcd_dat}), 32'(cap));
                check("setup", 32'(prev_bus), 32'(cap));
                check("rw", 32'(lcd_rw), 32'd0);
            end
            en_len = 0;
        end
        if (lcd_en) en_len++;
        if (!lcd_en && prev_en) begin
            check("en_len", 32'(en_len), 32'(EN_CYC));
            pulses++;
            hold_cnt = EN_CYC;
            if (pulses == 4 && init_at == NEVER) begin
                init_at = cyc + EN_CYC + LONG_WAIT;
                idle_at = init_at;
            end
        end
        if (hold_cnt > 0) begin
            check("hold_stable", 32'({lcd_rs, lcd_dat}), 32'(cap));
            hold_cnt--;
        end
        prev_en  = lcd_en;
        prev_bus = {lcd_rs, lcd_dat};

        init_exp = (cyc >= init_at);
        idle_m   = init_exp && (cyc >= idle_at);
        v = {req1_valid, req0_valid};
        g = 2'b00;
        if (idle_m) g = (v == 2'b11) ? (last_m ? 2'b01 : 2'b10) : v;
        check("ready", 32'({req1_ready, req0_ready}), 32'(g));
        check("init_done", 32'(init_done), 32'(init_exp));
        check("busy", 32'(busy), 32'(!idle_m));
        if (g != 2'b00) begin
            r = g[1] ? 1 : 0;
            exp_q.push_back(r == 1 ? {req1_rs, req1_data} : {req0_rs, req0_data});
            last_m  = g[1];
            idle_at = cyc + 2 + 2 * EN_CYC +
                      (r == 1 ? wait_len(req1_rs, req1_data) : wait_len(req0_rs, req0_data));
        end
        acc[0] = req0_ready && req0_valid;
        acc[1] = req1_ready && req1_valid;
        if (acc[0] || acc[1]) begin
            acc_total++;
            gap_last     = cyc - last_acc_cyc;
            last_acc_cyc = cyc;
            grants.push_back(acc[1] ? 1 : 0);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (acc[r]) begin
                pend[r] = 1'b0; prs[r] = 1'($urandom); pdat[r] = 8'($urandom); acc[r] = 1'b0;
            end
            if (!pend[r] && int'($urandom_range(0, 99)) < spawn_pct) begin
                pend[r] = 1'b1;
                prs[r]  = 1'($urandom_range(0, 1));
                pdat[r] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            end else if (pend[r] && int'($urandom_range(0, 99)) < wd_pct) begin
                pend[r] = 1'b0;
            end
        end
        req0_valid = pend[0]; req0_rs = prs[0]; req0_data = pdat[0];
        req1_valid = pend[1]; req1_rs = prs[1]; req1_data = pdat[1];
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_req(input int r, input bit rs, input logic [7:0] d);
        pend[r] = 1'b1; prs[r] = rs; pdat[r] = d;
    endtask

    task automatic clear_reqs();
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
    endtask

    task automatic run_until(input int target, input int bound);
        int n = 0;
        while (acc_total < target && n < bound) begin
            step();
            n++;
        end
        check("accept_timeout", 32'(acc_total), 32'(target));
    endtask

    task automatic reset_checks();
        check("rst_en", 32'(lcd_en), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_rw", 32'(lcd_rw), 32'd0);
        check("rst_dat", 32'(lcd_dat), 32'd0);
        check("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        check("rst_init", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int g0, n;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;

        // Data 0x41 held from reset release; must wait out the full init sequence.
        set_req(0, 1'b1, 8'h41); drive();
        run_until(acc_total + 1, 400);

        // Both requesters continuously valid: grants must alternate.
        g0 = grants.size();
        spawn_pct = 100;
        set_req(0, 1'b1, 8'h30); set_req(1, 1'b1, 8'h31); drive();
        run_until(acc_total + 6, 400);
        spawn_pct = 0;
        clear_reqs();
        for (int i = g0; i < grants.size(); i++)
            check("alternate", 32'(grants[i]), 32'(1 - grants[i-1]));

        // Clear command then data: accept spacing includes the long wait.
        set_req(1, 1'b0, 8'h01); drive();
        run_until(acc_total + 1, 200);
        set_req(0, 1'b1, 8'h42); drive();
        run_until(acc_total + 1, 200);
        check("gap_clear", 32'(gap_last), 32'(2 + 2 * EN_CYC + LONG_WAIT));
        clear_reqs();

        // req1 raises valid during the transfer and withdraws it inside WAIT.
        set_req(0, 1'b1, 8'h55); drive();
        run_until(acc_total + 1, 200);
        set_req(1, 1'b1, 8'h66); drive();
        repeat (8) step();
        pend[1] = 1'b0; drive();
        repeat (10) step();
        set_req(0, 1'b1, 8'h11); set_req(1, 1'b1, 8'h22); drive();
        run_until(acc_total + 1, 200);
        check("ptr_kept", 32'(grants[grants.size()-1]), 32'd1);
        clear_reqs();

        spawn_pct = 30; wd_pct = 3;
        repeat (1500) step();

        // Reset in the middle of an enable pulse.
        set_req(0, 1'b1, 8'h77); drive();
        n = 0;
        while (!lcd_en && n < 600) begin
            step();
            n++;
        end
        check("en_seen", 32'(lcd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_checks();
        spawn_pct = 0; wd_pct = 0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_req(0, 1'b1, 8'h61); set_req(1, 1'b1, 8'h62); drive();
        run_until(acc_total + 1, 400);
        check("rst_ptr", 32'(grants[grants.size()-1]), 32'd0);
        clear_reqs();

        spawn_pct = 40; wd_pct = 5;
        repeat (600) step();
        spawn_pct = 0; wd_pct = 0;
        clear_reqs();
        repeat (100) step();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd1602_sched.md
LCD1602_SCHED -- requirements
Module: lcd1602_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk, reset port rst_n.
REQ-002 Parameter EN_CYC, 16, clk cycles per lcd_en high phase and per low hold phase (legal range 1..65535).
REQ-003 Parameter SHORT_WAIT, 64, clk cycles of post-transfer wait for data writes and ordinary commands.
REQ-004 Parameter LONG_WAIT, 2048, clk cycles of post-transfer wait after command 0x01 (clear) or 0x02/0x03 (home).
REQ-005 Parameter POWER_WAIT, 1000, clk cycles from reset release to the first init command.
REQ-006 Port clk  in  1  system clock, rising edge.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Ports req0_valid / req1_valid  in  1 each  requester has a write pending.
REQ-009 Ports req0_rs / req1_rs  in  1 each  0 = command, 1 = character data.
REQ-010 Ports req0_data / req1_data  in  8 each  byte to write.
REQ-011 Ports req0_ready / req1_ready  out  1 each  one-cycle accept strobe.
REQ-012 Port lcd_rs  out  1  LCD register select.
REQ-013 Port lcd_rw  out  1  LCD read/write, constant 0.
REQ-014 Port lcd_en  out  1  LCD enable strobe.
REQ-015 Port lcd_dat  out  8  LCD data bus.
REQ-016 Port init_done  out  1  high once the init sequence completes.
REQ-017 Port busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: PWR_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-019 PWR_WAIT SHALL count POWER_WAIT cycles, then go to INIT_LOAD.
REQ-020 Init sequence, with rs=0, SHALL be 0x31, 0x0C, 0x06, 0x01, each run through SETUP/PULSE/HOLD/WAIT; after the fourth WAIT, init_done=1 and the FSM enters IDLE.
REQ-021 ready SHALL be asserted only in IDLE with init_done=1, for exactly one cycle, to one requester; a transfer occurs on valid&&ready.
REQ-022 On accept, rs and data SHALL be latched and the FSM SHALL enter SETUP on the next cycle.
REQ-023 SETUP: 1 cycle with lcd_rs/lcd_dat driven from the latch and lcd_en=0.
REQ-024 PULSE: EN_CYC cycles with lcd_en=1.
REQ-025 HOLD: EN_CYC cycles with lcd_en=0.
REQ-026 lcd_rs and lcd_dat SHALL stay stable from SETUP through the end of HOLD.
REQ-027 WAIT SHALL last LONG_WAIT cycles if rs=0 and data is 0x01, 0x02 or 0x03; otherwise SHORT_WAIT cycles. The FSM then returns to IDLE.
REQ-028 Minimum accept-to-accept spacing SHALL be 1+2*EN_CYC+wait+1 cycles.
REQ-029 Arbitration SHALL be 2-way round-robin: with both valid, grant the requester other than the last granted; with one valid, grant it; the pointer updates only on accept.
REQ-030 valid deasserted before ready SHALL cause no transfer and leave the pointer unchanged.
REQ-031 Requesters SHALL hold valid/rs/data until ready; changes after accept SHALL have no effect on the transfer in progress.
REQ-032 Cycle counters SHALL be 16 bits and SHALL not wrap: each terminates at its parameter value.

Reset
REQ-033 rst_n=0 SHALL immediately force lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_dat=0x00, ready=0, init_done=0, busy=1, state=PWR_WAIT, and arbitration pointer favouring req0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no further lcd_en pulse; the full init sequence SHALL be rerun after release.

Structure
REQ-035 Package lcd1602_pkg SHALL hold the state enum, the four init command constants, and the CLEAR/HOME opcodes.
REQ-036 The round-robin grant logic SHALL be a sub-module named lcd1602_rr_arb.

Verification
REQ-037 Reset release, EN_CYC=2, POWER_WAIT=10 -> 4 lcd_en pulses with lcd_dat 0x31, 0x0C, 0x06, 0x01 and rs=0; init_done rises after the 0x01 LONG_WAIT.
REQ-038 req0 valid, rs=1, data=0x41 -> req0_ready pulses once; lcd_dat=0x41, lcd_rs=1 in SETUP; lcd_en high for exactly EN_CYC cycles.
REQ-039 Both valid continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-040 Command 0x01 then data 0x42 -> gap between the two accepts equals 1+2*EN_CYC+LONG_WAIT+1.
REQ-041 rst_n low during PULSE -> lcd_en=0 in the same cycle; after release, the init sequence restarts and no stale byte is written.
REQ-042 Valid dropped during WAIT -> no ready, no lcd_en pulse, and the grant pointer is unchanged.
